// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for the multiplexed seven-segment display: qualifies each
// anode/cathode scan slot for stability and decodes it back to 5-bit symbol codes.
module ssd_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  An,
  input  logic [7:0]  Cath,
  input  logic        err_clr,
  output logic [39:0] digits,
  output logic [2:0]  cur_digit,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode
);

  localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);
  localparam logic [4:0] CODE_OFF = 5'b10000;
  localparam logic [4:0] CODE_BAD = 5'b11111;

  typedef enum logic [1:0] {
    AN_BLANK,
    AN_SINGLE,
    AN_MULTI
  } an_kind_e;

  typedef struct packed {
    logic       known;
    logic [4:0] code;
  } decode_t;

  // Segment order abcdefg, active-low; the decimal point never takes part.
  function automatic decode_t decode_segments(input logic [6:0] abcdefg);
    decode_t d;
    d.known = 1'b1;
    case (abcdefg)
      7'b0000001: d.code = 5'h00;
      7'b1001111: d.code = 5'h01;
      7'b0010010: d.code = 5'h02;
      7'b0000110: d.code = 5'h03;
      7'b1001100: d.code = 5'h04;
      7'b0100100: d.code = 5'h05;
      7'b0100000: d.code = 5'h06;
      7'b0001111: d.code = 5'h07;
      7'b0000000: d.code = 5'h08;
      7'b0000100: d.code = 5'h09;
      7'b0001000: d.code = 5'h0A;
      7'b1100000: d.code = 5'h0B;
      7'b0110001: d.code = 5'h0C;
      7'b1000010: d.code = 5'h0D;
      7'b0110000: d.code = 5'h0E;
      7'b0111000: d.code = 5'h0F;
      7'b1111111: d.code = 5'h10;
      7'b1000100: d.code = 5'h11;
      7'b0000010: d.code = 5'h12;
      7'b1110001: d.code = 5'h13;
      default: begin
        d.known = 1'b0;
        d.code  = CODE_BAD;
      end
    endcase
    return d;
  endfunction

  logic [15:0] samp;
  logic [7:0]  cnt;
  logic [7:0]  seen;
  logic [4:0]  digit_q [8];

  logic [15:0] sample_now;
  logic        same;
  logic        capture;
  an_kind_e    an_kind;
  logic [2:0]  an_idx;
  logic [3:0]  an_zeros;
  decode_t     dec;
  logic        digit_wr;
  logic [7:0]  seen_set;
  logic        frame_hit;
  logic        set_err_pattern;
  logic        set_err_anode;

  assign sample_now = {An, Cath};
  assign same       = (sample_now == samp);
  // One capture per stable run: only the edge that brings cnt up to STABLE.
  assign capture    = same && (cnt == STABLE - 8'd1);

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    an_zeros = 4'd0;
    an_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!samp[8+i]) begin
        an_zeros = an_zeros + 4'd1;
        an_idx   = 3'(i);
      end
    end
    if (an_zeros == 4'd0)      an_kind = AN_BLANK;
    else if (an_zeros == 4'd1) an_kind = AN_SINGLE;
    else                       an_kind = AN_MULTI;
  end

  always_comb begin
    dec             = decode_segments(samp[7:1]);
    digit_wr        = 1'b0;
    seen_set        = seen;
    frame_hit       = 1'b0;
    set_err_pattern = 1'b0;
    set_err_anode   = 1'b0;
    if (capture) begin
      case (an_kind)
        AN_SINGLE: begin
          digit_wr         = 1'b1;
          seen_set[an_idx] = 1'b1;
          frame_hit        = &seen_set;
          set_err_pattern  = !dec.known;
        end
        AN_MULTI: set_err_anode = 1'b1;
        default:  ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      samp       <= '1;
      cnt        <= '0;
      seen       <= '0;
      cur_digit  <= '0;
      frame_done <= 1'b0;
    end else begin
      samp       <= sample_now;
      frame_done <= frame_hit;
      if (!same)             cnt <= '0;
      else if (cnt < STABLE) cnt <= cnt + 8'd1;
      if (digit_wr) begin
        cur_digit <= an_idx;
        seen      <= frame_hit ? 8'h00 : seen_set;
      end
    end
  end

  // NOTE: the digit store is a small register file that must read back as
  // "off" after reset, so it is reset explicitly rather than left uninitialised.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= CODE_OFF;
    end else if (digit_wr) begin
      digit_q[an_idx] <= dec.code;
    end
  end

  // A new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      if (set_err_pattern) err_pattern <= 1'b1;
      else if (err_clr)    err_pattern <= 1'b0;
      if (set_err_anode)   err_anode   <= 1'b1;
      else if (err_clr)    err_anode   <= 1'b0;
    end
  end

  always_comb begin
    digits = '0;
    for (int i = 0; i < 8; i++) digits[5*i +: 5] = digit_q[i];
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Scoreboard bench for ssd_scan_decoder: slots are driven with known hold times and the
// expected display state is queued per capture; a negedge monitor compares every cycle.
module tb_ssd_scan_decoder;

  localparam int S = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  An = 8'hFF;
  logic [7:0]  Cath = 8'hFF;
  logic        err_clr = 1'b0;
  logic [39:0] digits;
  logic [2:0]  cur_digit;
  logic        frame_done;
  logic        err_pattern;
  logic        err_anode;

  ssd_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath), .err_clr(err_clr),
    .digits(digits), .cur_digit(cur_digit), .frame_done(frame_done),
    .err_pattern(err_pattern), .err_anode(err_anode)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Display symbol table (abcdefg, active-low) indexed by symbol code.
  localparam logic [6:0] PAT [20] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
    7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000,
    7'b0111000, 7'b1111111, 7'b1000100, 7'b0000010, 7'b1110001
  };

  function automatic logic [4:0] ref_decode(input logic [7:0] cath);
    for (int k = 0; k < 20; k++) if (PAT[k] == cath[7:1]) return 5'(k);
    return 5'd31;
  endfunction

  typedef struct {
    int          due;
    logic [39:0] digits;
    logic [2:0]  cur;
    logic        fd;
    logic        errp;
    logic        erra;
  } exp_t;

  exp_t q[$];

  // Reference model of the visible display state.
  logic [4:0]  m_d [8];
  logic [2:0]  m_cur;
  logic [7:0]  m_seen;
  logic        m_errp, m_erra;
  logic [15:0] prev;

  function automatic logic [39:0] m_pack();
    logic [39:0] p;
    for (int i = 0; i < 8; i++) p[5*i +: 5] = m_d[i];
    return p;
  endfunction

  task automatic push_state(input int due, input logic fd);
    exp_t e;
    e.due = due; e.digits = m_pack(); e.cur = m_cur; e.fd = fd;
    e.errp = m_errp; e.erra = m_erra;
    q.push_back(e);
  endtask

  task automatic model_capture(input logic [7:0] an, input logic [7:0] cath,
                               input bit clr, input int due);
    int zeros = 0;
    int idx = 0;
    logic new_p = 1'b0, new_a = 1'b0, fd = 1'b0;
    for (int i = 0; i < 8; i++) if (!an[i]) begin zeros++; idx = i; end
    if (zeros > 1) new_a = 1'b1;
    else if (zeros == 1) begin
      m_d[idx] = ref_decode(cath);
      new_p    = (m_d[idx] == 5'd31);
      m_cur    = 3'(idx);
      m_seen[idx] = 1'b1;
      if (m_seen == 8'hFF) begin fd = 1'b1; m_seen = 8'h00; end
    end
    m_errp = new_p ? 1'b1 : (clr ? 1'b0 : m_errp);
    m_erra = new_a ? 1'b1 : (clr ? 1'b0 : m_erra);
    push_state(due, fd);
  endtask

  // Drive one slot for `hold` edges; it is captured iff held at least S+1 edges.
  task automatic slot(input logic [7:0] an, input logic [7:0] cath, input int hold,
                      input bit clr_at_cap = 1'b0);
    int start = cyc;
    An = an; Cath = cath;
    if (hold >= S + 1) model_capture(an, cath, clr_at_cap, start + 1 + S);
    for (int k = 1; k <= hold; k++) begin
      @(posedge Clk); #1;
      if (clr_at_cap && k == S)     err_clr = 1'b1;
      if (clr_at_cap && k == S + 1) err_clr = 1'b0;
    end
    prev = {an, cath};
  endtask

  task automatic clr_pulse();
    int start = cyc;
    err_clr = 1'b1;
    @(posedge Clk); #1;
    err_clr = 1'b0;
    m_errp = 1'b0; m_erra = 1'b0;
    push_state(start + 1, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    An = 8'($urandom); Cath = 8'($urandom);
    for (int i = 0; i < 8; i++) m_d[i] = 5'b10000;
    m_cur = 3'd0; m_seen = 8'h00; m_errp = 1'b0; m_erra = 1'b0;
    push_state(cyc, 1'b0);
    repeat (2) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    prev = 16'hFFFF;
  endtask

  function automatic logic [7:0] sym(input int code);
    return {PAT[code], 1'b1};
  endfunction

  // Monitor: retire due expectations and compare the whole visible state.
  exp_t cur_exp;
  always @(negedge Clk) begin
    logic fd_exp;
    fd_exp = 1'b0;
    while (q.size() > 0 && q[0].due <= cyc) begin
      cur_exp = q.pop_front();
      fd_exp  = (cur_exp.due == cyc) && cur_exp.fd;
    end
    if (cyc > 0) begin
      check("digits",      64'(digits),      64'(cur_exp.digits));
      check("cur_digit",   64'(cur_digit),   64'(cur_exp.cur));
      check("frame_done",  64'(frame_done),  64'(fd_exp));
      check("err_pattern", 64'(err_pattern), 64'(cur_exp.errp));
      check("err_anode",   64'(err_anode),   64'(cur_exp.erra));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] an, cath;
    int hold, fd_count;
    @(posedge Clk); #1;
    do_reset();

    // Single slot, plain and with the decimal point lit.
    slot(8'hFE, 8'b00000011, 10);
    slot(8'hFE, 8'b00000010, 10);

    // Full frames: 1,2,3,Y,a,L,off,8 on digits 0..7, twice.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      int codes [8] = '{1, 2, 3, 17, 18, 19, 16, 8};
      for (int i = 0; i < 8; i++) slot(~(8'h01 << i), sym(codes[i]), 6);
    end
    check("frame_digits", 64'(digits),
          64'({5'b01000, 5'b10000, 5'b10011, 5'b10010,
               5'b10001, 5'b00011, 5'b00010, 5'b00001}));

    // Rescanning digit 3 mid-frame must not complete the frame early.
    slot(8'hFE, sym(4), 6); slot(8'hFD, sym(5), 6); slot(8'hF7, sym(6), 6);
    slot(8'hFB, sym(7), 6); slot(8'hF7, sym(9), 6);
    for (int i = 4; i < 8; i++) slot(~(8'h01 << i), sym(i), 6);

    // Glitch to "8" inside a digit-2 "5" slot.
    slot(8'hFB, sym(5), 8); slot(8'hFB, sym(8), 3); slot(8'hFB, sym(5), 8);

    // Bad pattern, sticky flag, clear, and clear colliding with a new error.
    slot(8'hEF, 8'b01010101, 8); slot(8'hEF, 8'b01010100, 8);
    clr_pulse();
    slot(8'hDF, 8'b01010100, 8, 1'b1);
    slot(8'hF3, sym(1), 8);
    clr_pulse();

    // Reset mid-frame: digits 0..3, reset, then 4..7 only.
    do_reset();
    for (int i = 0; i < 4; i++) slot(~(8'h01 << i), sym(i + 10), 6);
    do_reset();
    for (int i = 4; i < 8; i++) slot(~(8'h01 << i), sym(i + 10), 6);
    check("partial_d0_3_off", 64'(digits[19:0]), 64'({4{5'b10000}}));

    // Randomized scanning.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      do begin
        int r = $urandom_range(0, 9);
        if (r == 0)      an = 8'hFF;
        else if (r == 1) an = 8'($urandom) & ~(8'h01 << $urandom_range(0, 3))
                                           & ~(8'h10 << $urandom_range(0, 3));
        else             an = ~(8'h01 << $urandom_range(0, 7));
        if ($urandom_range(0, 9) < 7) cath = {PAT[$urandom_range(0, 19)], 1'($urandom)};
        else                          cath = 8'($urandom);
      end while ({an, cath} == prev);
      hold = $urandom_range(1, 8);
      if (hold >= S + 1 && $urandom_range(0, 19) == 0) slot(an, cath, hold, 1'b1);
      else slot(an, cath, hold);
      if (hold >= S + 1 && $urandom_range(0, 14) == 0) clr_pulse();
      if (n == 200) begin
        do_reset();
      end
    end

    repeat (10) begin @(posedge Clk); #1; end
    check("queue_drained", 64'(q.size()), 64'd0);
    fd_count = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
